// File: rtl/restoring_divider_pkg.sv
// Shared types and sizing helpers for the multi-cycle restoring divider.
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Iteration counter counts WIDTH-1 down to 0, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// Start/done handshake plus operand and result buses between a controller and the divider.
interface restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/restoring_divider_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract with a guard bit, restore on borrow.
module restoring_divider_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_r,
  output logic [WIDTH-1:0] next_q
);
  logic [WIDTH:0]   shifted_r_s;
  logic [WIDTH+1:0] trial_s;
  logic             borrow_s;

  assign shifted_r_s = {r, q[WIDTH-1]};
  assign trial_s     = {1'b0, shifted_r_s} - {2'b00, divisor};
  assign borrow_s    = trial_s[WIDTH+1];

  // R stays below the divisor, so the low WIDTH bits hold the kept value either way.
  always_comb begin
    next_r = shifted_r_s[WIDTH-1:0];
    if (borrow_s) begin
      next_r = shifted_r_s[WIDTH-1:0];
    end else begin
      next_r = trial_s[WIDTH-1:0];
    end
  end

  assign next_q = {q[WIDTH-2:0], ~borrow_s};
endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands (sign fix applied on entry to DONE).
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  restoring_divider_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] work_q_r;
  logic [WIDTH-1:0] dvsr_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             busy_r;
  logic             done_r;
  logic             div_zero_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic [WIDTH-1:0] step_r_s;
  logic [WIDTH-1:0] step_q_s;
  logic [WIDTH-1:0] fix_q_s;
  logic [WIDTH-1:0] fix_r_s;
  logic [WIDTH-1:0] cap_dividend_s;
  logic [WIDTH-1:0] cap_divisor_s;

  restoring_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .r       (acc_r),
    .q       (work_q_r),
    .divisor (dvsr_r),
    .next_r  (step_r_s),
    .next_q  (step_q_s)
  );

`ifdef DIVIDER_SIGNED_EN
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    if (x[WIDTH-1]) begin
      return ~x + WIDTH'(1);
    end else begin
      return x;
    end
  endfunction

  assign cap_dividend_s = magnitude(bus.dividend);
  assign cap_divisor_s  = magnitude(bus.divisor);

  // Quotient is negated on differing signs; remainder follows the dividend sign.
  always_comb begin
    fix_q_s = step_q_s;
    fix_r_s = step_r_s;
    if (q_neg_r) begin
      fix_q_s = ~step_q_s + WIDTH'(1);
    end else begin
      fix_q_s = step_q_s;
    end
    if (r_neg_r) begin
      fix_r_s = ~step_r_s + WIDTH'(1);
    end else begin
      fix_r_s = step_r_s;
    end
  end
`else
  assign cap_dividend_s = bus.dividend;
  assign cap_divisor_s  = bus.divisor;
  assign fix_q_s        = step_q_s;
  assign fix_r_s        = step_r_s;
`endif

  // Control FSM with counter, working registers and registered results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      acc_r       <= '0;
      work_q_r    <= '0;
      dvsr_r      <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      div_zero_r  <= 1'b0;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            busy_r   <= 1'b1;
            cnt_r    <= CNT_W'(WIDTH - 1);
            acc_r    <= '0;
            work_q_r <= cap_dividend_s;
            dvsr_r   <= cap_divisor_s;
            q_neg_r  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg_r  <= bus.dividend[WIDTH-1];
            if (bus.divisor == '0) begin
              state_r     <= DONE;
              done_r      <= 1'b1;
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
              div_zero_r  <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          acc_r    <= step_r_s;
          work_q_r <= step_q_s;
          if (cnt_r == '0) begin
            state_r     <= DONE;
            done_r      <= 1'b1;
            quotient_r  <= fix_q_s;
            remainder_r <= fix_r_s;
            div_zero_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.div_zero  = div_zero_r;
endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: cycle-level reference model plus directed vectors.
module tb_restoring_divider;
  localparam int W = 8;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  restoring_divider_if #(.WIDTH(W)) bus ();

  restoring_divider #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operator definitions.
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return '1;
`ifdef DIVIDER_SIGNED_EN
    if (a == 8'h80 && b == 8'hFF) return a;
    return W'($signed(a) / $signed(b));
`else
    return a / b;
`endif
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return a;
`ifdef DIVIDER_SIGNED_EN
    if (a == 8'h80 && b == 8'hFF) return '0;
    return W'($signed(a) % $signed(b));
`else
    return a % b;
`endif
  endfunction

  // Timing model: accepted start -> results after W edges (or next edge on divide-by-zero).
  logic         m_busy, m_done, m_dz, p_dz;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  int           m_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0; m_q <= '0; m_r <= '0; m_left <= 0;
      p_q <= '0; p_r <= '0; p_dz <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_done <= 1'b1; m_q <= p_q; m_r <= p_r; m_dz <= p_dz;
      end
      m_left <= m_left - 1;
    end else if (bus.start) begin
      m_busy <= 1'b1;
      if (bus.divisor == '0) begin
        m_done <= 1'b1; m_q <= '1; m_r <= bus.dividend; m_dz <= 1'b1;
      end else begin
        m_left <= W;
        p_q <= ref_q(bus.dividend, bus.divisor);
        p_r <= ref_r(bus.dividend, bus.divisor);
        p_dz <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("done", 32'(bus.done), 32'(m_done));
    check("quotient", 32'(bus.quotient), 32'(m_q));
    check("remainder", 32'(bus.remainder), 32'(m_r));
    check("div_zero", 32'(bus.div_zero), 32'(m_dz));
  end

  task automatic run_op(input string name, input logic [W-1:0] dd, input logic [W-1:0] ds,
                        input logic [W-1:0] exp_q, input logic [W-1:0] exp_r, input logic exp_dz,
                        input int exp_lat, input bit repulse);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = dd; bus.divisor = ds;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = W'($urandom); bus.divisor = W'($urandom);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      if (repulse && cyc == 3) begin
        bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({name, "_q"}, 32'(bus.quotient), 32'(exp_q));
    check({name, "_r"}, 32'(bus.remainder), 32'(exp_r));
    check({name, "_dz"}, 32'(bus.div_zero), 32'(exp_dz));
  endtask

  initial begin
    int pulses;
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_q", 32'(bus.quotient), 32'd0);
    reset_n = 1'b1;

    // Abort 13/4 mid-iteration.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd13; bus.divisor = 8'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_outs", 32'({bus.quotient, bus.remainder, bus.div_zero}), 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    pulses = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    check("abort_idle", 32'(bus.busy), 32'd0);

`ifdef DIVIDER_SIGNED_EN
    run_op("s100_7_repulse", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 1'b1);
    run_op("s9_3_b2b", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9, 1'b0);
    run_op("sm7_2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9, 1'b0);
    run_op("s7_m2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 9, 1'b0);
    run_op("sm128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9, 1'b0);
    run_op("sm100_7", 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 9, 1'b0);
    run_op("sm5_0", 8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1, 1'b0);
    run_op("s3_m9", 8'h03, 8'hF7, 8'h00, 8'h03, 1'b0, 9, 1'b0);
`else
    run_op("u200_7_repulse", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, 1'b1);
    run_op("u9_3_b2b", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9, 1'b0);
    run_op("u5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9, 1'b0);
    run_op("u255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, 1'b0);
    run_op("u37_0", 8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 1, 1'b0);
    run_op("u255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9, 1'b0);
    run_op("u250_16", 8'd250, 8'd16, 8'd15, 8'd10, 1'b0, 9, 1'b0);
    run_op("u0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 9, 1'b0);
`endif

    // Results must hold while idle with garbage on the operand bus.
    bus.dividend = 8'd77; bus.divisor = 8'd0;
    repeat (4) @(negedge clk);
    check("idle_hold_busy", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
